// File: rtl/if_stage_pkg.sv
// Shared configuration for the instruction-fetch stage: widths, reset word,
// FSM state encodings and small address helpers.
package if_stage_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;
  localparam int ByteLen = 8;
  localparam int CntLen  = 2;

  localparam logic [InstLen-1:0] ZERO_WORD = '0;
  localparam logic [AddrLen-1:0] ZERO_ADDR = '0;
  localparam logic [AddrLen-1:0] INST_STEP = AddrLen'(InstLen / ByteLen);
  localparam logic [CntLen-1:0]  LAST_LANE = '1;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } if_state_t;

  // Byte address of lane cnt within the word starting at pc.
  function automatic logic [AddrLen-1:0] byte_addr(input logic [AddrLen-1:0] pc,
                                                   input logic [CntLen-1:0]  cnt);
    return pc + {{(AddrLen-CntLen){1'b0}}, cnt};
  endfunction

  // Word-sequential successor, wrapping modulo 2^AddrLen.
  function automatic logic [AddrLen-1:0] next_pc(input logic [AddrLen-1:0] pc);
    return pc + INST_STEP;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: assembles a 32-bit little-endian word from four byte
// reads, presents it to decode and advances the PC once decode consumes it.
module if_stage
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               stall_i,
  input  logic               jump_i,
  input  logic [AddrLen-1:0] jump_addr_i,
  output logic               mem_req_o,
  output logic [AddrLen-1:0] mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [ByteLen-1:0] mem_data_i,
  output logic [AddrLen-1:0] pc_o,
  output logic [InstLen-1:0] inst_o,
  output logic               if_id_rdy_o
);

  if_state_t                    state_reg;
  logic [AddrLen-1:0]           pc_reg;
  logic [CntLen-1:0]            cnt_reg;
  // Lanes 0..2 only; the top byte goes straight from mem_data_i into inst_o.
  logic [InstLen-ByteLen-1:0]   inst_buf_reg;
  logic [InstLen-ByteLen-1:0]   inst_buf_next;
  logic                         byte_take;

  // Requests are withheld during reset, while frozen and while redirecting.
  assign mem_req_o  = !rst && rdy && !jump_i && (state_reg == ST_FETCH);
  assign mem_addr_o = byte_addr(pc_reg, cnt_reg);
  assign byte_take  = mem_req_o && mem_ack_i;

  always_comb begin
    inst_buf_next = inst_buf_reg;
    case (cnt_reg)
      2'd0:    inst_buf_next[7:0]   = mem_data_i;
      2'd1:    inst_buf_next[15:8]  = mem_data_i;
      2'd2:    inst_buf_next[23:16] = mem_data_i;
      default: inst_buf_next        = inst_buf_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= ZERO_ADDR;
      cnt_reg      <= '0;
      inst_buf_reg <= '0;
      pc_o         <= ZERO_ADDR;
      inst_o       <= ZERO_WORD;
      if_id_rdy_o  <= 1'b0;
    end else if (rdy) begin
      if (jump_i) begin
        // Redirect wins over stall and over any byte arriving this cycle.
        state_reg   <= ST_FETCH;
        pc_reg      <= jump_addr_i;
        cnt_reg     <= '0;
        if_id_rdy_o <= 1'b0;
      end else begin
        case (state_reg)
          ST_FETCH: begin
            if (byte_take) begin
              cnt_reg      <= cnt_reg + 2'd1;
              inst_buf_reg <= inst_buf_next;
              if (cnt_reg == LAST_LANE) begin
                inst_o      <= {mem_data_i, inst_buf_reg};
                pc_o        <= pc_reg;
                if_id_rdy_o <= 1'b1;
                state_reg   <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (!stall_i) begin
              pc_reg      <= next_pc(pc_reg);
              if_id_rdy_o <= 1'b0;
              state_reg   <= ST_FETCH;
            end
          end
          default: state_reg <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized
// handshake run scored against a word-level model of instruction memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        if_id_rdy_o;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i), .jump_i(jump_i),
    .jump_addr_i(jump_addr_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .pc_o(pc_o),
    .inst_o(inst_o), .if_id_rdy_o(if_id_rdy_o)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory contents: a fixed program word at 0, hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h93;
      32'd1:   return 8'h00;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hC3;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  always_comb mem_data_i = mem_byte(mem_addr_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0;
    jump_addr_i = 32'd0; mem_ack_i = 1'b1;
    #2 rst = 1'b1;
    #2;
    checks++;
    if ({mem_req_o, mem_addr_o, pc_o, inst_o, if_id_rdy_o} !== 98'd0) begin
      errors++;
      $display("FAIL reset_values: req=%b addr=%h pc=%h inst=%h rdy=%b, required all zero",
               mem_req_o, mem_addr_o, pc_o, inst_o, if_id_rdy_o);
    end
    $display("reset: outputs req=%b addr=%h pc=%h inst=%h v=%b", mem_req_o, mem_addr_o, pc_o, inst_o, if_id_rdy_o);
  endtask

  task automatic test_first_fetch();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL first_request: req=%b addr=%h, required 1 / 00000000", mem_req_o, mem_addr_o);
    end
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (if_id_rdy_o !== (e == 4)) begin
        errors++;
        $display("FAIL first_latency edge %0d: if_id_rdy_o=%b, required %b", e, if_id_rdy_o, (e == 4));
      end
    end
    stall_i = 1'b1;
    checks++;
    if (inst_o !== 32'h00100093 || pc_o !== 32'd0) begin
      errors++;
      $display("FAIL first_word: inst=%h pc=%h, required 00100093 / 00000000", inst_o, pc_o);
    end
    $display("first_fetch: inst=%h pc=%h v=%b", inst_o, pc_o, if_id_rdy_o);
  endtask

  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (if_id_rdy_o !== 1'b1 || pc_o !== 32'd0 || inst_o !== 32'h00100093) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: v=%b pc=%h inst=%h, required 1 / 00000000 / 00100093",
                 c, if_id_rdy_o, pc_o, inst_o);
      end
    end
    stall_i = 1'b0;
    tick();
    checks++;
    if (if_id_rdy_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'd4) begin
      errors++;
      $display("FAIL stall_release: v=%b req=%b addr=%h, required 0 / 1 / 00000004",
               if_id_rdy_o, mem_req_o, mem_addr_o);
    end
    $display("stall: released, next request addr=%h", mem_addr_o);
  endtask

  task automatic test_jump_mid();
    tick();
    tick();
    jump_i = 1'b1; jump_addr_i = 32'h100;
    #1;
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL jump_gates_req: req=%b, required 0", mem_req_o);
    end
    tick();
    jump_i = 1'b0;
    #1;
    checks++;
    if (if_id_rdy_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL jump_mid_redirect: v=%b req=%b addr=%h, required 0 / 1 / 00000100",
               if_id_rdy_o, mem_req_o, mem_addr_o);
    end
    repeat (4) tick();
    checks++;
    if (if_id_rdy_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== word_at(32'h100)) begin
      errors++;
      $display("FAIL jump_mid_word: v=%b pc=%h inst=%h, required 1 / 00000100 / %h",
               if_id_rdy_o, pc_o, inst_o, word_at(32'h100));
    end
    $display("jump_mid: word at %h = %h", pc_o, inst_o);
  endtask

  task automatic test_jump_stall_hold();
    stall_i = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h200;
    tick();
    jump_i = 1'b0; stall_i = 1'b0;
    #1;
    checks++;
    if (if_id_rdy_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL jump_over_stall: v=%b req=%b addr=%h, required 0 / 1 / 00000200",
               if_id_rdy_o, mem_req_o, mem_addr_o);
    end
    repeat (4) tick();
    checks++;
    if (if_id_rdy_o !== 1'b1 || pc_o !== 32'h200 || inst_o !== word_at(32'h200)) begin
      errors++;
      $display("FAIL jump_stall_word: v=%b pc=%h inst=%h, required 1 / 00000200 / %h",
               if_id_rdy_o, pc_o, inst_o, word_at(32'h200));
    end
    $display("jump_stall_hold: word at %h = %h", pc_o, inst_o);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic        prev_valid;
    logic        prev_cons;
    logic        cur_valid;
    int          rdy_low_run;
    int          delivered;
    exp_pc = $urandom() & 32'hFFFF_FFFC;
    jump_i = 1'b1; jump_addr_i = exp_pc; rdy = 1'b1;
    tick();
    jump_i = 1'b0;
    prev_valid = 1'b0; prev_cons = 1'b0; prev_pc = '0; prev_inst = '0;
    rdy_low_run = 0; delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      cur_valid = if_id_rdy_o;
      if (prev_valid && prev_cons) begin
        exp_pc = exp_pc + 32'd4;
        checks++;
        if (cur_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_consume cycle %0d: v=%b, required 0", i, cur_valid);
        end
      end else if (prev_valid) begin
        checks++;
        if (cur_valid !== 1'b1 || pc_o !== prev_pc || inst_o !== prev_inst) begin
          errors++;
          $display("FAIL rand_hold cycle %0d: v=%b pc=%h inst=%h, required 1 / %h / %h",
                   i, cur_valid, pc_o, inst_o, prev_pc, prev_inst);
        end
      end else if (cur_valid) begin
        delivered++;
        checks++;
        if (pc_o !== exp_pc || inst_o !== word_at(exp_pc)) begin
          errors++;
          $display("FAIL rand_word cycle %0d: pc=%h inst=%h, required %h / %h",
                   i, pc_o, inst_o, exp_pc, word_at(exp_pc));
        end else begin
          $display("rand: inst #%0d pc=%h inst=%h", delivered, pc_o, inst_o);
        end
      end
      if (rdy_low_run > 0) begin
        rdy = 1'b0; rdy_low_run--;
      end else if ($urandom_range(0, 29) == 0) begin
        rdy = 1'b0; rdy_low_run = 1;
      end else begin
        rdy = 1'b1;
      end
      mem_ack_i = ($urandom_range(0, 2) != 0);
      stall_i   = ($urandom_range(0, 3) == 0);
      prev_valid = cur_valid;
      prev_cons  = cur_valid && rdy && !stall_i;
      prev_pc    = pc_o;
      prev_inst  = inst_o;
      #1;
      checks++;
      if (mem_req_o !== (rdy && !cur_valid)) begin
        errors++;
        $display("FAIL rand_req cycle %0d: req=%b, required %b", i, mem_req_o, (rdy && !cur_valid));
      end
    end
    checks++;
    if (delivered < 50) begin
      errors++;
      $display("FAIL rand_progress: delivered=%0d, required at least 50", delivered);
    end
    rdy = 1'b1; stall_i = 1'b0; mem_ack_i = 1'b1;
  endtask

  task automatic test_wrap_reset();
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (if_id_rdy_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || inst_o !== word_at(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_word: v=%b pc=%h inst=%h, required 1 / fffffffc / %h",
               if_id_rdy_o, pc_o, inst_o, word_at(32'hFFFF_FFFC));
    end
    tick();
    checks++;
    if (if_id_rdy_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL wrap_next_addr: v=%b req=%b addr=%h, required 0 / 1 / 00000000",
               if_id_rdy_o, mem_req_o, mem_addr_o);
    end
    $display("wrap: next request addr=%h", mem_addr_o);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o, pc_o, inst_o, if_id_rdy_o} !== 98'd0) begin
      errors++;
      $display("FAIL async_reset: req=%b addr=%h pc=%h inst=%h v=%b, required all zero",
               mem_req_o, mem_addr_o, pc_o, inst_o, if_id_rdy_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL restart_addr: req=%b addr=%h, required 1 / 00000000", mem_req_o, mem_addr_o);
    end
    repeat (4) tick();
    checks++;
    if (if_id_rdy_o !== 1'b1 || pc_o !== 32'd0 || inst_o !== 32'h00100093) begin
      errors++;
      $display("FAIL restart_word: v=%b pc=%h inst=%h, required 1 / 00000000 / 00100093",
               if_id_rdy_o, pc_o, inst_o);
    end
    $display("reset_restart: inst=%h pc=%h", inst_o, pc_o);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_jump_mid();
    test_jump_stall_hold();
    test_random();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port rdy, input, 1, global ready; when low, all state holds.
REQ-004 SHALL have port stall_i, input, 1, decode stall; when high, the held instruction is not consumed.
REQ-005 SHALL have port jump_i, input, 1, redirect request from execute.
REQ-006 SHALL have port jump_addr_i, input, 32, redirect target PC.
REQ-007 SHALL have port mem_req_o, output, 1, byte-read request to the memory controller.
REQ-008 SHALL have port mem_addr_o, output, 32, byte address of the current request.
REQ-009 SHALL have port mem_ack_i, input, 1, request accepted; mem_data_i is valid in the same cycle.
REQ-010 SHALL have port mem_data_i, input, 8, returned byte.
REQ-011 SHALL have port pc_o, output, 32, PC of the held instruction.
REQ-012 SHALL have port inst_o, output, 32, held instruction word.
REQ-013 SHALL have port if_id_rdy_o, output, 1, instruction valid toward decode.

Function
REQ-014 SHALL implement two states: FETCH (assembling bytes) and HOLD (instruction presented).
REQ-015 SHALL keep internal pc_reg and a 2-bit byte counter cnt; mem_addr_o = pc_reg + cnt in FETCH.
REQ-016 SHALL assert mem_req_o in FETCH only, when rdy=1 and jump_i=0.
REQ-017 SHALL, on mem_ack_i=1 in FETCH, write mem_data_i into inst byte lane cnt (little-endian: cnt 0 -> bits 7:0) and increment cnt.
REQ-018 SHALL, on an ack with cnt=3, load inst_o with the assembled word, set pc_o=pc_reg and if_id_rdy_o=1, and enter HOLD; cnt wraps to 0.
REQ-019 SHALL, in HOLD with stall_i=0 and jump_i=0, set pc_reg=pc_reg+4 (modulo 2^32; 0xFFFFFFFC wraps to 0), clear if_id_rdy_o and return to FETCH.
REQ-020 SHALL, in HOLD with stall_i=1, hold pc_o, inst_o and if_id_rdy_o unchanged.
REQ-021 SHALL, on jump_i=1 in any state, set pc_reg=jump_addr_i, cnt=0, if_id_rdy_o=0 and state FETCH at the next edge; jump overrides stall_i and any same-cycle ack (that byte is discarded).
REQ-022 SHALL ignore mem_ack_i when mem_req_o=0.
REQ-023 SHALL freeze state, cnt, pc_reg and outputs when rdy=0, and deassert mem_req_o.
REQ-024 SHALL achieve latency of 4 cycles from FETCH entry to if_id_rdy_o=1 with ack every cycle, and throughput of one instruction per 5 cycles.
REQ-025 SHALL not alter pc_o or inst_o while if_id_rdy_o=1, except on reset or jump.

Reset
REQ-026 SHALL, while rst=1, force state=FETCH, pc_reg=0, cnt=0, pc_o=0, inst_o=0, if_id_rdy_o=0, mem_req_o=0 and mem_addr_o=0 asynchronously.
REQ-027 SHALL abandon any partial word on reset mid-fetch; fetch resumes at address 0 in the first cycle after rst falls.

Structure
REQ-028 SHALL take AddrLen, InstLen, ZERO_WORD and the state encodings from the shared config include.
REQ-029 SHALL be a single module; no sub-module is required.

Verification
REQ-030 SHALL cover: ack tied high, memory 0..3 = 93 00 10 00 -> if_id_rdy_o=1 in cycle 5, inst_o=0x00100093, pc_o=0.
REQ-031 SHALL cover: stall_i=1 for 3 cycles in HOLD -> outputs stable; after release, the next fetch uses mem_addr_o=4.
REQ-032 SHALL cover: jump_i=1 with jump_addr_i=0x100 during cnt=2 -> if_id_rdy_o stays 0 and the next request is at 0x100.
REQ-033 SHALL cover: jump_i and stall_i both high in HOLD -> if_id_rdy_o=0 next cycle and fetch restarts at the target.
REQ-034 SHALL cover: ack deasserted randomly and rdy low for 2 cycles mid-word -> same assembled word, no byte lost or duplicated.
REQ-035 SHALL cover: pc_reg=0xFFFFFFFC consumed -> next mem_addr_o=0; rst pulse mid-fetch -> all outputs return to the REQ-026 values immediately.
